// File: rtl/pipelined_add_sub_if.sv
// rtl/pipelined_add_sub_if.sv - operand/result stream bundle for pipelined_add_sub
interface pipelined_add_sub_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - S-stage chunked adder/subtractor with stream handshake
// Optional signed saturation of sum on overflow: define PIPE_ADD_SAT_EN.
module pipelined_add_sub #(
  parameter int N = 16,
  parameter int S = 2
) (
  input logic               clk,
  input logic               rst,
  pipelined_add_sub_if.slave bus
);
  localparam int C = N / S;

  logic [N-1:0] a_q [S];
  logic [N-1:0] b_q [S];
  logic [N-1:0] s_q [S];
  logic         c_q [S];
  logic         v_q [S];
  logic         ovf_q;
  logic         zero_q;

  logic [N-1:0] a_d [S];
  logic [N-1:0] b_d [S];
  logic [N-1:0] s_d [S];
  logic         c_d [S];
  logic         v_d [S];
  logic [N-1:0] sum_d;
  logic         ovf_d;
  logic         zero_d;
  logic         msb_carry;
  logic         stall;

  assign stall         = v_q[S-1] & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = v_q[S-1];
  assign bus.sum       = s_q[S-1];
  assign bus.cout      = c_q[S-1];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

  // Each stage adds its own chunk with the carry left by the stage before it;
  // operands ride along so later stages still see their upper chunks.
  always_comb begin : comb_stages
    logic [N-1:0] a_i;
    logic [N-1:0] b_i;
    logic [N-1:0] s_i;
    logic         c_i;
    logic         v_i;
    logic [C:0]   part;
    a_i  = '0;
    b_i  = '0;
    s_i  = '0;
    c_i  = 1'b0;
    v_i  = 1'b0;
    part = '0;
    for (int k = 0; k < S; k++) begin
      if (k == 0) begin
        a_i = bus.a;
        b_i = bus.sub ? ~bus.b : bus.b;
        s_i = '0;
        c_i = bus.sub ? ~bus.cin : bus.cin;
        v_i = bus.in_valid;
      end else begin
        a_i = a_q[k-1];
        b_i = b_q[k-1];
        s_i = s_q[k-1];
        c_i = c_q[k-1];
        v_i = v_q[k-1];
      end
      part = {1'b0, a_i[k*C +: C]} + {1'b0, b_i[k*C +: C]} + {{C{1'b0}}, c_i};
      s_i[k*C +: C] = part[C-1:0];
      a_d[k] = a_i;
      b_d[k] = b_i;
      s_d[k] = s_i;
      c_d[k] = part[C];
      v_d[k] = v_i;
    end
  end

  always_comb begin
    msb_carry = a_d[S-1][N-1] ^ b_d[S-1][N-1] ^ s_d[S-1][N-1];
    ovf_d     = msb_carry ^ c_d[S-1];
    sum_d     = s_d[S-1];
`ifdef PIPE_ADD_SAT_EN
    if (ovf_d) begin
      sum_d = a_d[S-1][N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
`endif
    zero_d = (sum_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < S; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < S; k++) begin
        v_q[k] <= v_d[k];
        c_q[k] <= c_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= (k == S - 1) ? sum_d : s_d[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb/tb_pipelined_add_sub.sv - directed N=16/S=2 checks plus random sweeps at N=32/S=4 and N=8/S=1
module tb_pipelined_add_sub;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic sweep_go;
  int   sweeps_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands' unsigned and signed values.
  function automatic void ref_op(input int n, input longint unsigned a, input longint unsigned b,
                                 input bit cin, input bit sub, output longint unsigned s,
                                 output bit co, output bit ov, output bit z);
    longint unsigned mask;
    longint unsigned cu;
    longint          sa, sb, ci, r, hi, lo;
    mask = (64'd1 << n) - 64'd1;
    cu   = cin;
    ci   = cin;
    hi   = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo   = -(64'sd1 <<< (n - 1));
    sa   = (((a >> (n - 1)) & 64'd1) != 0) ? longint'(a) - longint'(64'd1 << n) : longint'(a);
    sb   = (((b >> (n - 1)) & 64'd1) != 0) ? longint'(b) - longint'(64'd1 << n) : longint'(b);
    r    = sub ? (sa - sb - ci) : (sa + sb + ci);
    ov   = (r > hi) || (r < lo);
    co   = sub ? (a >= b + cu) : ((((a + b + cu) >> n) & 64'd1) != 0);
    s    = (sub ? (a - b - cu) : (a + b + cu)) & mask;
`ifdef PIPE_ADD_SAT_EN
    if (ov) s = (r > hi) ? $unsigned(hi) : ($unsigned(lo) & mask);
`endif
    z = (s == 0);
  endfunction

  pipelined_add_sub_if #(.N(16)) bus0 ();
  pipelined_add_sub #(.N(16), .S(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int NN = (g == 0) ? 32 : 8;
    localparam int SS = (g == 0) ? 4 : 1;
    pipelined_add_sub_if #(.N(NN)) bus ();
    pipelined_add_sub #(.N(NN), .S(SS)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    longint unsigned q_sum[$];
    logic [2:0]      q_flg[$];

    initial begin
      int              sent, got, cyc, sel;
      longint unsigned va, vb, mask, es;
      bit              ec, eo, ez;
      logic [2:0]      f;
      mask = (64'd1 << NN) - 64'd1;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
      bus.out_ready = 1'b1;
      sent = 0; got = 0; cyc = 0;
      wait (sweep_go);
      while (got < 1000 && cyc < 10000) begin
        @(negedge clk);
        cyc++;
        sel = $urandom_range(0, 7);
        va  = (sel == 0) ? mask : (sel == 1) ? (mask >> 1) : ({$urandom, $urandom} & mask);
        sel = $urandom_range(0, 7);
        vb  = (sel == 0) ? mask : (sel == 1) ? (mask >> 1) : ({$urandom, $urandom} & mask);
        bus.a         = va[NN-1:0];
        bus.b         = vb[NN-1:0];
        bus.cin       = 1'($urandom_range(0, 1));
        bus.sub       = 1'($urandom_range(0, 1));
        bus.in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 2) != 0);
        #1;
        if (bus.in_valid && bus.in_ready) begin
          ref_op(NN, va, vb, bus.cin, bus.sub, es, ec, eo, ez);
          q_sum.push_back(es);
          q_flg.push_back({ec, eo, ez});
          sent++;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (q_sum.size() == 0) begin
            check_eq($sformatf("sw%0d_spurious", NN), q_sum.size(), 1);
          end else begin
            es = q_sum.pop_front();
            f  = q_flg.pop_front();
            check_eq($sformatf("sw%0d_sum", NN), bus.sum, es);
            check_eq($sformatf("sw%0d_cout", NN), bus.cout, f[2]);
            check_eq($sformatf("sw%0d_ovf", NN), bus.ovf, f[1]);
            check_eq($sformatf("sw%0d_zero", NN), bus.zero, f[0]);
          end
          got++;
        end
      end
      bus.in_valid = 1'b0;
      check_eq($sformatf("sw%0d_count", NN), got, 1000);
      sweeps_done++;
    end
  end

  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sub, input logic [15:0] es,
                      input logic ec, input logic eo, input logic ez);
    @(negedge clk);
    bus0.in_valid = 1'b1; bus0.a = a; bus0.b = b; bus0.cin = cin; bus0.sub = sub;
    bus0.out_ready = 1'b1;
    #1 check_eq({tag, "_in_ready"}, bus0.in_ready, 1);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    #1 check_eq({tag, "_early"}, bus0.out_valid, 0);
    @(negedge clk);
    #1;
    check_eq({tag, "_valid"}, bus0.out_valid, 1);
    check_eq({tag, "_sum"}, bus0.sum, es);
    check_eq({tag, "_cout"}, bus0.cout, ec);
    check_eq({tag, "_ovf"}, bus0.ovf, eo);
    check_eq({tag, "_zero"}, bus0.zero, ez);
  endtask

  initial begin
    int          sent, got;
    logic [15:0] held;
    n_checks = 0; n_fail = 0; sweep_go = 1'b0; sweeps_done = 0;
    rst = 1'b1;
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0; bus0.sub = 1'b0;
    bus0.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", bus0.out_valid, 0);
    check_eq("rst_sum", bus0.sum, 0);
    check_eq("rst_cout", bus0.cout, 0);
    check_eq("rst_ovf", bus0.ovf, 0);
    check_eq("rst_zero", bus0.zero, 0);
    rst = 1'b0;
    @(negedge clk);
    #1 check_eq("rst_in_ready", bus0.in_ready, 1);

    op16("add", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    op16("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
`ifdef PIPE_ADD_SAT_EN
    op16("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    op16("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
`else
    op16("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    op16("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`endif
    op16("sub_borrow", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    op16("sub_cin", 16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);

    // Stream of 8 with a 3-cycle downstream stall once the pipe is full.
    sent = 0; got = 0; held = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge clk);
      bus0.in_valid  = (sent < 8);
      bus0.a         = 16'(sent);
      bus0.b         = 16'h0100;
      bus0.cin       = 1'b0;
      bus0.sub       = 1'b0;
      bus0.out_ready = !(cyc >= 4 && cyc < 7);
      #1;
      if (cyc == 4) held = bus0.sum;
      if (cyc == 5) begin
        check_eq("stall_in_ready", bus0.in_ready, 0);
        check_eq("stall_valid", bus0.out_valid, 1);
        check_eq("stall_hold", bus0.sum, held);
      end
      if (bus0.in_valid && bus0.in_ready) sent++;
      if (bus0.out_valid && bus0.out_ready) begin
        check_eq("stream_sum", bus0.sum, 16'h0100 + 16'(got));
        got++;
      end
    end
    check_eq("stream_count", got, 8);
    bus0.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_eq("stream_no_dup", bus0.out_valid, 0);

    // Two transactions in flight when rst pulses: neither may come out.
    @(negedge clk);
    bus0.in_valid = 1'b1; bus0.a = 16'h1111; bus0.b = 16'h2222; bus0.out_ready = 1'b1;
    @(negedge clk);
    bus0.a = 16'h3333; bus0.out_ready = 1'b0;
    @(negedge clk);
    bus0.in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus0.out_ready = 1'b1;
    #1;
    check_eq("midrst_out_valid", bus0.out_valid, 0);
    check_eq("midrst_in_ready", bus0.in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check_eq("midrst_dropped", bus0.out_valid, 0);
    end
    op16("post_rst", 16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0);

    sweep_go = 1'b1;
    for (int i = 0; i < 30000 && sweeps_done < 2; i++) @(negedge clk);
    check_eq("sweep_done", sweeps_done, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
